// File: rtl/sa_result_drain.sv
// sa_result_drain: snapshots the systolic-array result matrix on a rising valid edge,
// pulses the array clear, then streams the snapshot out one row per handshake.
module sa_result_drain #(
    parameter int D_W  = 8,
    parameter int SA_R = 16,
    parameter int SA_C = 16
) (
    input  logic                      I_CLK,
    input  logic                      I_ASYN_RSTN,
    input  logic                      I_SYNC_RSTN,
    input  logic                      I_SA_VLD,
    input  logic [D_W-1:0]            I_SA_OUT [SA_R][SA_C],
    input  logic [$clog2(SA_R+1)-1:0] I_ROWS,
    output logic                      O_SA_CLR,
    output logic                      O_ROW_VLD,
    input  logic                      I_ROW_RDY,
    output logic [D_W-1:0]            O_ROW_DATA [SA_C],
    output logic [$clog2(SA_R)-1:0]   O_ROW_IDX,
    output logic                      O_ROW_LAST,
    output logic                      O_BUSY,
    output logic                      O_DONE,
    output logic                      O_OVF
);
    localparam int RW = $clog2(SA_R+1);
    localparam int IW = $clog2(SA_R);
    typedef enum logic {S_IDLE, S_DRAIN} state_e;
    state_e         state_q, state_d;
    logic           vld_dly_q, vld_dly_d;
    logic           clr_q, clr_d, done_q, done_d, ovf_q, ovf_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [RW-1:0]  nrows_q, nrows_d;
    logic [D_W-1:0] buf_q [SA_R][SA_C];
    logic           busy, cap, last, xfer, load;
    always_comb begin
        busy      = state_q == S_DRAIN;
        cap       = I_SA_VLD & ~vld_dly_q;
        last      = busy && (RW'(idx_q) == nrows_q - RW'(1));
        xfer      = busy & I_ROW_RDY;
        state_d   = state_q;
        idx_d     = idx_q;
        nrows_d   = nrows_q;
        clr_d     = 1'b0;
        done_d    = 1'b0;
        ovf_d     = ovf_q | (cap & busy);
        vld_dly_d = I_SA_VLD;
        if (cap && !busy) begin
            state_d = S_DRAIN;
            idx_d   = '0;
            clr_d   = 1'b1;
            nrows_d = (I_ROWS == '0 || I_ROWS > RW'(SA_R)) ? RW'(SA_R) : I_ROWS;
        end else if (xfer) begin
            state_d = last ? S_IDLE : S_DRAIN;
            idx_d   = last ? '0 : idx_q + IW'(1);
            done_d  = last;
        end
        // synchronous reset folds into next-state so the flops carry only the async one
        if (!I_SYNC_RSTN) begin
            state_d   = S_IDLE;
            idx_d     = '0;
            nrows_d   = '0;
            clr_d     = 1'b0;
            done_d    = 1'b0;
            ovf_d     = 1'b0;
            vld_dly_d = 1'b0;
        end
        load = !busy && state_d == S_DRAIN;
    end
    always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
        if (!I_ASYN_RSTN) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            nrows_q   <= '0;
            clr_q     <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            vld_dly_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            nrows_q   <= nrows_d;
            clr_q     <= clr_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            vld_dly_q <= vld_dly_d;
        end
    end
    always_ff @(posedge I_CLK) begin
        if (load) buf_q <= I_SA_OUT;
    end
    always_comb begin
        for (int c = 0; c < SA_C; c++) O_ROW_DATA[c] = busy ? buf_q[idx_q][c] : '0;
    end
    assign O_SA_CLR   = clr_q;
    assign O_ROW_VLD  = busy;
    assign O_ROW_IDX  = idx_q;
    assign O_ROW_LAST = last;
    assign O_BUSY     = busy;
    assign O_DONE     = done_q;
    assign O_OVF      = ovf_q;
endmodule

// File: tb/tb_sa_result_drain.sv
// tb_sa_result_drain: directed stimulus pushes expected rows to a queue; a negedge monitor
// pops and compares every accepted row and checks rows hold under back-pressure.
module tb_sa_result_drain;
    localparam int D_W = 8, SA_R = 16, SA_C = 16;
    localparam int RW = $clog2(SA_R+1), IW = $clog2(SA_R), FW = SA_C*D_W;
    logic            I_CLK = 0, I_ASYN_RSTN = 1, I_SYNC_RSTN = 1, I_SA_VLD = 0, I_ROW_RDY = 1;
    logic [D_W-1:0]  I_SA_OUT [SA_R][SA_C];
    logic [RW-1:0]   I_ROWS = '0;
    logic            O_SA_CLR, O_ROW_VLD, O_ROW_LAST, O_BUSY, O_DONE, O_OVF;
    logic [D_W-1:0]  O_ROW_DATA [SA_C];
    logic [IW-1:0]   O_ROW_IDX;
    typedef struct packed {
        logic [IW-1:0] idx;
        logic          last;
        logic [FW-1:0] d;
    } row_t;
    row_t     exp_q[$];
    int       n_chk = 0, n_pass = 0, n_clr = 0, n_done = 0;
    bit       bp_en = 0;
    logic [3:0] bp_pat = 4'b1001;
    sa_result_drain #(.D_W(D_W), .SA_R(SA_R), .SA_C(SA_C)) dut (
        .I_CLK(I_CLK), .I_ASYN_RSTN(I_ASYN_RSTN), .I_SYNC_RSTN(I_SYNC_RSTN),
        .I_SA_VLD(I_SA_VLD), .I_SA_OUT(I_SA_OUT), .I_ROWS(I_ROWS),
        .O_SA_CLR(O_SA_CLR), .O_ROW_VLD(O_ROW_VLD), .I_ROW_RDY(I_ROW_RDY),
        .O_ROW_DATA(O_ROW_DATA), .O_ROW_IDX(O_ROW_IDX), .O_ROW_LAST(O_ROW_LAST),
        .O_BUSY(O_BUSY), .O_DONE(O_DONE), .O_OVF(O_OVF)
    );
    always #5 I_CLK = ~I_CLK;
    task automatic chk(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask
    function automatic logic [FW-1:0] flat_out();
        logic [FW-1:0] f;
        for (int c = 0; c < SA_C; c++) f[c*D_W +: D_W] = O_ROW_DATA[c];
        return f;
    endfunction
    initial forever begin
        @(posedge I_CLK);
        #2;
        I_ROW_RDY = bp_en ? bp_pat[0] : 1'b1;
        bp_pat = {bp_pat[0], bp_pat[3:1]};
    end
    // monitor: compare each accepted row and verify stalled rows do not move
    initial begin
        bit            prev_stall = 0;
        logic [IW-1:0] p_idx = '0;
        logic [FW-1:0] p_data = '0;
        row_t          e;
        forever begin
            @(negedge I_CLK);
            if (prev_stall && I_ASYN_RSTN && I_SYNC_RSTN) begin
                chk("hold_idx", O_ROW_IDX, p_idx);
                chk("hold_data", flat_out(), p_data);
            end
            if (O_ROW_VLD && I_ROW_RDY && I_ASYN_RSTN && I_SYNC_RSTN) begin
                chk("row_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("row_idx", O_ROW_IDX, e.idx);
                    chk("row_last", O_ROW_LAST, e.last);
                    chk("row_data", flat_out(), e.d);
                end
            end
            prev_stall = O_ROW_VLD && !I_ROW_RDY;
            p_idx = O_ROW_IDX;
            p_data = flat_out();
            if (O_SA_CLR) n_clr++;
            if (O_DONE) n_done++;
        end
    end
    task automatic present(input int seed, input int rows);
        int   n;
        row_t e;
        @(posedge I_CLK);
        #2;
        for (int r = 0; r < SA_R; r++)
            for (int c = 0; c < SA_C; c++) I_SA_OUT[r][c] = D_W'(r*SA_C + c + seed);
        n = (rows == 0 || rows > SA_R) ? SA_R : rows;
        for (int r = 0; r < n; r++) begin
            e.idx = IW'(r);
            e.last = (r == n-1);
            for (int c = 0; c < SA_C; c++) e.d[c*D_W +: D_W] = D_W'(r*SA_C + c + seed);
            exp_q.push_back(e);
        end
        I_ROWS = RW'(rows);
        I_SA_VLD = 1;
    endtask
    task automatic start_drain();
        @(posedge I_CLK);
        @(negedge I_CLK);
        chk("clr_t1", O_SA_CLR, 1);
        chk("busy_t1", O_BUSY, 1);
        chk("vld_t1", O_ROW_VLD, 1);
        chk("idx_t1", O_ROW_IDX, 0);
    endtask
    task automatic finish_drain(input int exp_done, input int clr0);
        int k = 1;
        do begin
            @(negedge I_CLK);
            k++;
        end while (!O_DONE && k < 400);
        chk("done_seen", O_DONE, 1);
        if (exp_done > 0) chk("done_cycle", k, exp_done);
        chk("clr_pulses", n_clr - clr0, 1);
        @(negedge I_CLK);
        chk("done_pulse_len", O_DONE, 0);
        chk("vld_after_done", O_ROW_VLD, 0);
        chk("busy_after_done", O_BUSY, 0);
        chk("rows_left", exp_q.size(), 0);
    endtask
    task automatic drain(input int seed, input int rows, input int exp_done, input bit hold);
        int clr0 = n_clr;
        present(seed, rows);
        start_drain();
        @(posedge I_CLK);
        #1 I_SA_VLD = hold;
        finish_drain(exp_done, clr0);
    endtask
    task automatic chk_reset_vals();
        chk("rst_clr", O_SA_CLR, 0);
        chk("rst_vld", O_ROW_VLD, 0);
        chk("rst_last", O_ROW_LAST, 0);
        chk("rst_busy", O_BUSY, 0);
        chk("rst_done", O_DONE, 0);
        chk("rst_ovf", O_OVF, 0);
        chk("rst_idx", O_ROW_IDX, 0);
        chk("rst_data", flat_out(), 0);
    endtask
    task automatic reset_mid(input bit async_rst);
        int k = 0, d0;
        present(17, 0);
        start_drain();
        @(posedge I_CLK);
        #1 I_SA_VLD = 0;
        while (O_ROW_IDX != 7 && k < 50) begin
            @(negedge I_CLK);
            k++;
        end
        chk("reached_row7", O_ROW_IDX, 7);
        @(posedge I_CLK);
        #3;
        d0 = n_done;
        if (async_rst) I_ASYN_RSTN = 0;
        else I_SYNC_RSTN = 0;
        exp_q.delete();
        if (!async_rst) @(posedge I_CLK);
        @(negedge I_CLK);
        chk_reset_vals();
        @(posedge I_CLK);
        #1;
        I_ASYN_RSTN = 1;
        I_SYNC_RSTN = 1;
        repeat (3) @(negedge I_CLK);
        chk("no_done_after_rst", n_done - d0, 0);
        chk("idle_after_rst", O_BUSY, 0);
        drain(21, 3, 4, 0);
    endtask
    initial begin
        int  clr0, k;
        bit  bad;
        #1 I_ASYN_RSTN = 0;
        repeat (3) @(negedge I_CLK);
        chk_reset_vals();
        @(posedge I_CLK);
        #1 I_ASYN_RSTN = 1;
        repeat (2) @(negedge I_CLK);
        drain(0, 0, 17, 0);
        bp_en = 1;
        drain(3, 0, 0, 0);
        bp_en = 0;
        drain(5, 5, 6, 0);
        drain(7, 20, 17, 0);
        // overflow: a second rising edge during row 3 with different data
        clr0 = n_clr;
        present(11, 0);
        start_drain();
        @(posedge I_CLK);
        #1 I_SA_VLD = 0;
        k = 0;
        while (O_ROW_IDX != 3 && k < 50) begin
            @(negedge I_CLK);
            k++;
        end
        for (int r = 0; r < SA_R; r++)
            for (int c = 0; c < SA_C; c++) I_SA_OUT[r][c] = D_W'(r*SA_C + c + 99);
        I_SA_VLD = 1;
        @(negedge I_CLK);
        chk("ovf_set", O_OVF, 1);
        chk("ovf_still_busy", O_BUSY, 1);
        finish_drain(0, clr0);
        I_SA_VLD = 0;
        repeat (4) @(negedge I_CLK);
        chk("ovf_sticky", O_OVF, 1);
        chk("ovf_no_recapture", O_BUSY, 0);
        // held valid: no re-capture while the array stays un-cleared
        clr0 = n_clr;
        drain(13, 0, 17, 1);
        bad = 0;
        repeat (40) begin
            @(negedge I_CLK);
            bad |= O_ROW_VLD | O_SA_CLR | O_BUSY;
        end
        chk("held_quiet", bad, 0);
        chk("held_one_clr", n_clr - clr0, 1);
        I_SA_VLD = 0;
        reset_mid(0);
        reset_mid(1);
        repeat (3) @(negedge I_CLK);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
